// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: serial bit-pattern transmitter.
// Latches a pattern, length and repeat count on a start handshake, then shifts
// the pattern out MSB-first one bit per clock. Idle gaps can be placed between
// repetitions. All outputs are registered.
module serial_pattern_gen #(
   parameter int   PAT_W    = 5,
   parameter int   LEN_W    = 3,
   parameter int   CNT_W    = 4,
   parameter int   GAP      = 1,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             out,
   output logic             valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   // The gap counter keeps at least one bit so the design still elaborates when GAP=0
   localparam int               GAP_CW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [LEN_W-1:0]  PAT_MAX  = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   reps_left_q, reps_left_d;
   logic [GAP_CW-1:0]  gap_q, gap_d;
   logic               out_d, valid_d, frame_start_d, busy_d, done_d;

   logic [LEN_W-1:0]   len_in_eff;
   logic [CNT_W-1:0]   reps_in_eff;

   // Select one bit of a pattern by shifting, so the index width need not match the pattern width
   function automatic logic pick_bit(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] idx);
      logic [PAT_W-1:0] shifted;
      shifted = pat >> idx;
      return shifted[0];
   endfunction

   // Clamp the requested length to the pattern width and treat a repeat count of zero as one
   always_comb begin
      len_in_eff  = (len > PAT_MAX) ? PAT_MAX : len;
      reps_in_eff = (reps == '0) ? CNT_ONE : reps;
   end

   // Next-state and next-output logic; outputs default to the idle line level
   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      len_d         = len_q;
      idx_d         = idx_q;
      reps_left_d   = reps_left_q;
      gap_d         = gap_q;
      out_d         = IDLE_LVL;
      valid_d       = 1'b0;
      frame_start_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  pat_d         = pattern;
                  len_d         = len_in_eff;
                  idx_d         = len_in_eff - LEN_ONE;
                  reps_left_d   = reps_in_eff - CNT_ONE;
                  state_d       = ST_SEND;
                  out_d         = pick_bit(pattern, len_in_eff - LEN_ONE);
                  valid_d       = 1'b1;
                  frame_start_d = 1'b1;
                  busy_d        = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (idx_q != '0) begin
               idx_d   = idx_q - LEN_ONE;
               out_d   = pick_bit(pat_q, idx_q - LEN_ONE);
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else if (reps_left_q != '0) begin
               if (GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
                  busy_d  = 1'b1;
               end else begin
                  idx_d         = len_q - LEN_ONE;
                  reps_left_d   = reps_left_q - CNT_ONE;
                  out_d         = pick_bit(pat_q, len_q - LEN_ONE);
                  valid_d       = 1'b1;
                  frame_start_d = 1'b1;
                  busy_d        = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_q == '0) begin
               state_d       = ST_SEND;
               idx_d         = len_q - LEN_ONE;
               reps_left_d   = reps_left_q - CNT_ONE;
               out_d         = pick_bit(pat_q, len_q - LEN_ONE);
               valid_d       = 1'b1;
               frame_start_d = 1'b1;
               busy_d        = 1'b1;
            end else begin
               gap_d  = gap_q - GAP_CW'(1);
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched transfer parameters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         reps_left_q <= '0;
         gap_q       <= '0;
         out         <= IDLE_LVL;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         reps_left_q <= reps_left_d;
         gap_q       <= gap_d;
         out         <= out_d;
         valid       <= valid_d;
         frame_start <= frame_start_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: directed and randomized transfers for serial_pattern_gen,
// checked cycle by cycle against an expected-waveform list built from the transfer rules.
module tb_serial_pattern_gen;

   localparam int   PAT_W    = 5;
   localparam int   LEN_W    = 3;
   localparam int   CNT_W    = 4;
   localparam int   GAP      = 1;
   localparam logic IDLE_LVL = 1'b0;

   typedef struct packed {
      logic o;
      logic v;
      logic fs;
      logic b;
      logic d;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [PAT_W-1:0] pattern = '0;
   logic [LEN_W-1:0] len = '0;
   logic [CNT_W-1:0] reps = '0;
   logic             abort = 1'b0;
   logic             out, valid, frame_start, busy, done;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t idle_e;

   serial_pattern_gen #(
      .PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(GAP), .IDLE_LVL(IDLE_LVL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
      .abort(abort), .out(out), .valid(valid), .frame_start(frame_start), .busy(busy), .done(done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compare all five outputs against one expected record
   task automatic checkOutput(input string tag, input exp_t e);
      n_cmp++;
      assert (out === e.o) else begin
         n_err++;
         $error("FAIL %s out: observed %b expected %b", tag, out, e.o);
      end
      n_cmp++;
      assert (valid === e.v) else begin
         n_err++;
         $error("FAIL %s valid: observed %b expected %b", tag, valid, e.v);
      end
      n_cmp++;
      assert (frame_start === e.fs) else begin
         n_err++;
         $error("FAIL %s frame_start: observed %b expected %b", tag, frame_start, e.fs);
      end
      n_cmp++;
      assert (busy === e.b) else begin
         n_err++;
         $error("FAIL %s busy: observed %b expected %b", tag, busy, e.d == 1'b1 ? 1'b0 : e.b);
      end
      n_cmp++;
      assert (done === e.d) else begin
         n_err++;
         $error("FAIL %s done: observed %b expected %b", tag, done, e.d);
      end
   endtask

   // Expected waveform of one transfer, one record per cycle after the accepting edge
   task automatic buildExpected(input logic [PAT_W-1:0] pat, input int ln, input int rp);
      int le, re;
      le = (ln > PAT_W) ? PAT_W : ln;
      re = (rp == 0) ? 1 : rp;
      exp_q.delete();
      if (le != 0) begin
         for (int r = 0; r < re; r++) begin
            for (int i = le - 1; i >= 0; i--)
               exp_q.push_back('{o: pat[i], v: 1'b1, fs: (i == le - 1), b: 1'b1, d: 1'b0});
            if (r < re - 1)
               for (int g = 0; g < GAP; g++)
                  exp_q.push_back('{o: IDLE_LVL, v: 1'b0, fs: 1'b0, b: 1'b1, d: 1'b0});
         end
      end
      exp_q.push_back('{o: IDLE_LVL, v: 1'b0, fs: 1'b0, b: 1'b0, d: 1'b1});
   endtask

   // Present a start request at a falling edge and advance to the first cycle after acceptance
   task automatic applyStimulus(input logic [PAT_W-1:0] pat, input int ln, input int rp);
      start   = 1'b1;
      pattern = pat;
      len     = LEN_W'(ln);
      reps    = CNT_W'(rp);
      buildExpected(pat, ln, rp);
      @(negedge clk);
      start   = 1'b0;
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom);
      reps    = CNT_W'($urandom);
   endtask

   // Walk the expected list; stray start pulses and input changes while busy must have no effect.
   // Ends at the falling edge inside the done cycle.
   task automatic playExpected(input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         checkOutput($sformatf("%s[%0d]", tag, i), exp_q[i]);
         if (i < exp_q.size() - 1) begin
            start   = 1'($urandom);
            pattern = PAT_W'($urandom);
            len     = LEN_W'($urandom);
            reps    = CNT_W'($urandom);
            @(negedge clk);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   // Play the first k records, then abort and confirm the line goes idle with no done pulse
   task automatic playAbort(input string tag, input int k);
      for (int i = 0; i < k; i++) begin
         checkOutput($sformatf("%s[%0d]", tag, i), exp_q[i]);
         @(negedge clk);
      end
      checkOutput($sformatf("%s[%0d]", tag, k), exp_q[k]);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s_post[%0d]", tag, i), idle_e);
         @(negedge clk);
      end
   endtask

   initial begin
      int ln, rp;
      logic [PAT_W-1:0] pat;
      logic chain;
      idle_e = '{o: IDLE_LVL, v: 1'b0, fs: 1'b0, b: 1'b0, d: 1'b0};

      // Reset state
      #1;
      checkOutput("reset", idle_e);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("after_reset", idle_e);

      // Single repetition of 10010
      $display("[TB] single repetition");
      applyStimulus(5'b10010, 5, 1);
      playExpected("t1");
      @(negedge clk);
      checkOutput("t1_idle", idle_e);

      // Three repetitions with gaps
      $display("[TB] three repetitions");
      applyStimulus(5'b10010, 5, 3);
      playExpected("t2");
      // Back-to-back: new start in the done cycle
      $display("[TB] back-to-back transfer");
      applyStimulus(5'b01101, 4, 2);
      playExpected("t3");
      @(negedge clk);
      checkOutput("t3_idle", idle_e);

      // Abort during the third bit of the first repetition
      $display("[TB] abort in SEND");
      applyStimulus(5'b10110, 5, 2);
      playAbort("t4", 2);
      // Abort during the gap
      $display("[TB] abort in GAP");
      applyStimulus(5'b11001, 3, 2);
      playAbort("t4g", 3);

      // Abort in IDLE blocks a simultaneous start
      start   = 1'b1;
      abort   = 1'b1;
      len     = 3'd5;
      pattern = 5'b11111;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("idle_abort0", idle_e);
      @(negedge clk);
      checkOutput("idle_abort1", idle_e);

      // Asynchronous reset between edges during SEND
      $display("[TB] async reset mid-transfer");
      applyStimulus(5'b10010, 5, 2);
      checkOutput("t5_pre", exp_q[0]);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_async", idle_e);
      @(negedge clk);
      checkOutput("t5_held", idle_e);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(5'b10010, 5, 1);
      playExpected("t5_after");
      @(negedge clk);

      // Boundary values
      $display("[TB] boundary values");
      applyStimulus(5'b10101, 0, 2);
      playExpected("len0");
      @(negedge clk);
      checkOutput("len0_idle", idle_e);
      applyStimulus(5'b10011, 7, 1);
      playExpected("len7");
      @(negedge clk);
      applyStimulus(5'b01011, 3, 0);
      playExpected("reps0");
      @(negedge clk);

      // Randomized transfers, some chained back-to-back
      $display("[TB] randomized transfers");
      for (int n = 0; n < 12; n++) begin
         pat   = PAT_W'($urandom);
         ln    = $urandom_range(0, 7);
         rp    = $urandom_range(0, 3);
         chain = 1'($urandom);
         applyStimulus(pat, ln, rp);
         playExpected($sformatf("rnd%0d", n));
         if (!chain) begin
            @(negedge clk);
            checkOutput($sformatf("rnd%0d_idle", n), idle_e);
         end
      end
      @(negedge clk);
      checkOutput("final_idle", idle_e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
